ahb_ram_slave: RTL and testbench

AHB-Lite responder for the on-chip data RAM window at 0xF000_0000 (1 KiB), the slave on port 1 of the two-slave AHB arbiter. It accepts single transfers from the arbiter's slave port. It performs byte, halfword and word reads and writes to an internal word-organised array. It inserts a configurable number of wait states and returns a two-cycle ERROR response for illegal accesses.

---
 rtl/ahb_ram_slave.sv | 129 ++++++++++++
 tb/tb_ahb_ram_slave.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_ram_slave.sv
// AHB-Lite responder for a word-organised RAM window: 1+WAIT_STATES cycle OKAY data phases, 2-cycle ERROR.
// HREADY low stalls the master; address inputs are sampled only while HREADY is high.
module ahb_ram_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'hF000_0000,
  parameter int          MEM_BYTES   = 1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBUST,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic [1:0]  HRESP,
  output logic        HREADY
);

  localparam int          MEM_WORDS = MEM_BYTES / 4;
  localparam int          IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);
  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [1:0]  RESP_ERR  = 2'b01;

  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;

  state_t           state;
  logic [1:0]       wait_cnt;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       lane_q;
  logic [1:0]       size_q;
  logic             write_q;
  logic [31:0]      mem [MEM_WORDS];

  logic [31:0]      offset;
  logic             accept;
  logic             illegal;
  logic [3:0]       byte_en;
  logic             unused_bits;

  assign offset  = HADDR - ADDR_BASE;
  assign accept  = HSEL && HTRANS[1] && HREADY;
  assign illegal = (HSIZE > 3'd2) ||
                   (HSIZE == 3'd1 && HADDR[0]) ||
                   (HSIZE == 3'd2 && HADDR[1:0] != 2'b00) ||
                   (offset >= MEM_LIMIT);

  // Burst type, SEQ/NONSEQ distinction and offset bits outside the word index carry no meaning here.
  assign unused_bits = ^{HBUST, HTRANS[0], offset[31:IDX_W+2], offset[1:0]};

  // HREADY/HRESP are registered alongside the state so they never see an input path.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= IDLE;
      wait_cnt <= 2'd0;
      idx_q    <= '0;
      lane_q   <= 2'd0;
      size_q   <= 2'd0;
      write_q  <= 1'b0;
      HREADY   <= 1'b1;
      HRESP    <= RESP_OKAY;
    end else begin
      case (state)
        WAIT: begin
          wait_cnt <= wait_cnt - 2'd1;
          if (wait_cnt == 2'd1) begin
            state  <= DATA;
            HREADY <= 1'b1;
          end
        end
        ERR1: begin
          state  <= ERR2;
          HREADY <= 1'b1;
          HRESP  <= RESP_ERR;
        end
        default: begin
          if (accept) begin
            idx_q   <= offset[IDX_W+1:2];
            lane_q  <= HADDR[1:0];
            size_q  <= HSIZE[1:0];
            write_q <= HWRITE;
            if (illegal) begin
              state  <= ERR1;
              HREADY <= 1'b0;
              HRESP  <= RESP_ERR;
            end else if (WAIT_STATES == 0) begin
              state  <= DATA;
              HREADY <= 1'b1;
              HRESP  <= RESP_OKAY;
            end else begin
              state    <= WAIT;
              wait_cnt <= 2'(WAIT_STATES);
              HREADY   <= 1'b0;
              HRESP    <= RESP_OKAY;
            end
          end else begin
            state  <= IDLE;
            HREADY <= 1'b1;
            HRESP  <= RESP_OKAY;
          end
        end
      endcase
    end
  end

  always_comb begin
    byte_en = 4'b0000;
    case (size_q)
      2'd0:    byte_en[lane_q] = 1'b1;
      2'd1:    byte_en = lane_q[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  // Array contents deliberately survive reset; only the control path is cleared.
  always_ff @(posedge HCLK) begin
    if (state == DATA && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HRDATA = (state == DATA && !write_q) ? mem[idx_q] : 32'h0;

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Bench for ahb_ram_slave: three instances (0, 2, 3 wait states) checked against a byte-array model.
module tb_ahb_ram_slave;

  localparam logic [31:0] BASE = 32'hF000_0000;
  localparam int          MEMB = 1024;
  localparam int          WS_TAB [3] = '{0, 2, 3};

  typedef struct packed {
    logic        idle;
    logic [1:0]  kind;
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  logic        HCLK = 1'b0;
  logic [2:0]  rst_n;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [31:0] rdata [3];
  logic [1:0]  resp [3];
  logic        rdy [3];
  int          sel = 0;

  logic        o_rdy;
  logic [1:0]  o_resp;
  logic [31:0] o_rdata;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_rd;
  logic [7:0]  mdl [3][MEMB];
  xfer_t       q [$];

  always #5 HCLK = ~HCLK;

  ahb_ram_slave #(.ADDR_BASE(BASE), .MEM_BYTES(MEMB), .WAIT_STATES(0)) u_ws0 (
    .HCLK(HCLK), .HRESETn(rst_n[0]), .HSEL(hsel && (sel == 0)), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBUST(hburst), .HWDATA(hwdata),
    .HRDATA(rdata[0]), .HRESP(resp[0]), .HREADY(rdy[0]));

  ahb_ram_slave #(.ADDR_BASE(BASE), .MEM_BYTES(MEMB), .WAIT_STATES(2)) u_ws2 (
    .HCLK(HCLK), .HRESETn(rst_n[1]), .HSEL(hsel && (sel == 1)), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBUST(hburst), .HWDATA(hwdata),
    .HRDATA(rdata[1]), .HRESP(resp[1]), .HREADY(rdy[1]));

  ahb_ram_slave #(.ADDR_BASE(BASE), .MEM_BYTES(MEMB), .WAIT_STATES(3)) u_ws3 (
    .HCLK(HCLK), .HRESETn(rst_n[2]), .HSEL(hsel && (sel == 2)), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBUST(hburst), .HWDATA(hwdata),
    .HRDATA(rdata[2]), .HRESP(resp[2]), .HREADY(rdy[2]));

  always_comb begin
    o_rdy   = rdy[0];
    o_resp  = resp[0];
    o_rdata = rdata[0];
    if (sel == 1) begin
      o_rdy = rdy[1]; o_resp = resp[1]; o_rdata = rdata[1];
    end else if (sel == 2) begin
      o_rdy = rdy[2]; o_resp = resp[2]; o_rdata = rdata[2];
    end
  end

  // ---------------- reference model ----------------
  function automatic xfer_t mk(logic idle, logic [1:0] kind, logic [31:0] addr, logic wr,
                               logic [2:0] sz, logic [31:0] wd);
    xfer_t t;
    t.idle = idle; t.kind = kind; t.addr = addr; t.write = wr; t.size = sz; t.wdata = wd;
    return t;
  endfunction

  function automatic bit is_err(xfer_t t);
    logic [31:0] off;
    off = t.addr - BASE;
    return (t.size > 3'd2) || (t.size == 3'd1 && t.addr[0]) ||
           (t.size == 3'd2 && t.addr[1:0] != 2'b00) || (off >= 32'(MEMB));
  endfunction

  function automatic logic [31:0] model_word(int s, logic [31:0] addr);
    int w;
    w = int'((addr - BASE) & 32'hFFFF_FFFC);
    return {mdl[s][w+3], mdl[s][w+2], mdl[s][w+1], mdl[s][w]};
  endfunction

  task automatic model_write(int s, xfer_t t);
    int n, off, a;
    n   = 1 << t.size;
    off = int'(t.addr - BASE);
    for (int b = 0; b < n; b++) begin
      a = (off / n) * n + b;
      mdl[s][a] = t.wdata[8*(a % 4) +: 8];
    end
  endtask

  // ---------------- bus driving ----------------
  task automatic drive_addr(xfer_t t);
    hsel   = 1'b1;
    haddr  = t.addr;
    htrans = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
    hwrite = t.write;
    hsize  = t.size;
    hburst = 3'($urandom);
  endtask

  task automatic drive_idle(int k);
    haddr  = BASE + 32'($urandom_range(0, MEMB - 1));
    hwrite = 1'($urandom);
    hsize  = 3'($urandom_range(0, 2));
    hburst = 3'($urandom);
    case (k)
      0:       begin hsel = 1'b1; htrans = 2'b00; end
      1:       begin hsel = 1'b1; htrans = 2'b01; end
      default: begin hsel = 1'b0; htrans = {1'b1, 1'($urandom)}; end
    endcase
  endtask

  task automatic drive_junk();
    hsel   = 1'($urandom);
    haddr  = ($urandom_range(0, 1) == 1) ? BASE + 32'($urandom_range(0, MEMB - 1)) : $urandom;
    htrans = 2'($urandom);
    hwrite = 1'($urandom);
    hsize  = 3'($urandom);
    hburst = 3'($urandom);
  endtask

  // Plays the queue as a pipelined master and checks every data-phase cycle against the model.
  task automatic run_queue();
    xfer_t       cur, nxt;
    bit          cur_v, nxt_v, rdy_now, exp_rdy, cerr;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rd;
    int          wcnt, cyc, s;
    cur_v = 0; wcnt = 0; cyc = 0; s = sel;
    cur = '0; nxt = '0;
    while ((q.size() > 0 || cur_v) && cyc < 4000) begin
      cyc++;
      rdy_now = o_rdy;
      hwdata  = (cur_v && cur.write) ? cur.wdata : $urandom;
      nxt_v   = 0;
      if (!rdy_now) drive_junk();
      else if (q.size() > 0) begin
        nxt = q.pop_front();
        if (nxt.idle) drive_idle(int'(nxt.kind));
        else begin
          drive_addr(nxt);
          nxt_v = 1;
        end
      end else drive_idle($urandom_range(0, 2));
      @(negedge HCLK);
      if (cur_v) begin
        cerr     = is_err(cur);
        exp_rdy  = cerr ? (wcnt >= 1) : (wcnt >= WS_TAB[s]);
        exp_resp = cerr ? 2'b01 : 2'b00;
        exp_rd   = (!cerr && !cur.write && exp_rdy) ? model_word(s, cur.addr) : 32'h0;
      end else begin
        exp_rdy = 1'b1; exp_resp = 2'b00; exp_rd = 32'h0;
      end
      checks++;
      if (o_rdy !== exp_rdy) begin
        failures++;
        $display("FAIL hready inst=%0d addr=%h got=%b exp=%b", s, cur.addr, o_rdy, exp_rdy);
      end
      checks++;
      if (o_resp !== exp_resp) begin
        failures++;
        $display("FAIL hresp inst=%0d addr=%h got=%b exp=%b", s, cur.addr, o_resp, exp_resp);
      end
      checks++;
      if (o_rdata !== exp_rd) begin
        failures++;
        $display("FAIL hrdata inst=%0d addr=%h got=%h exp=%h", s, cur.addr, o_rdata, exp_rd);
      end
      if (cur_v && exp_rdy && !cur.write && !is_err(cur)) last_rd = o_rdata;
      @(posedge HCLK);
      if (rdy_now) begin
        if (cur_v && cur.write && !is_err(cur)) model_write(s, cur);
        cur_v = nxt_v; cur = nxt; wcnt = 0;
      end else begin
        wcnt++;
        if (wcnt > 8) begin
          checks++; failures++;
          $display("FAIL stall inst=%0d waits=%0d limit=8", s, wcnt);
          cur_v = 0;
          q.delete();
        end
      end
      #1;
    end
    if (cyc >= 4000) begin
      checks++; failures++;
      $display("FAIL run_timeout inst=%0d cycles=%0d", s, cyc);
    end
    hsel = 1'b0; htrans = 2'b00;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 3'b000; hsel = 1'b0; htrans = 2'b00; haddr = 32'h0; hwrite = 1'b0;
    hsize = 3'd0; hburst = 3'd0; hwdata = 32'h0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rdy[i] !== 1'b1 || resp[i] !== 2'b00 || rdata[i] !== 32'h0) begin
        failures++;
        $display("FAIL reset_state inst=%0d got=%b/%b/%h exp=1/00/0", i, rdy[i], resp[i], rdata[i]);
      end
    end
    rst_n = 3'b111;
    @(posedge HCLK); #1;
  endtask

  task automatic test_word_b2b();
    sel = 0; last_rd = 32'hFFFF_FFFF;
    q.push_back(mk(0, 0, BASE + 32'h10, 1, 3'd2, 32'hDEADBEEF));
    q.push_back(mk(0, 0, BASE + 32'h10, 0, 3'd2, 32'h0));
    run_queue();
    checks++;
    if (last_rd !== 32'hDEADBEEF) begin
      failures++; $display("FAIL word_b2b got=%h exp=deadbeef", last_rd);
    end
  endtask

  task automatic test_lanes();
    sel = 0; last_rd = 32'hFFFF_FFFF;
    q.push_back(mk(0, 0, BASE + 32'h20, 1, 3'd0 + 3'd2, 32'h0));
    q.push_back(mk(0, 0, BASE + 32'h21, 1, 3'd0, {16'($urandom), 8'hAA, 8'($urandom)}));
    q.push_back(mk(0, 0, BASE + 32'h22, 1, 3'd1, {16'h5555, 16'($urandom)}));
    q.push_back(mk(0, 0, BASE + 32'h20, 0, 3'd2, 32'h0));
    run_queue();
    checks++;
    if (last_rd !== 32'h5555AA00) begin
      failures++; $display("FAIL lanes got=%h exp=5555aa00", last_rd);
    end
  endtask

  task automatic test_wait();
    logic [31:0] v;
    sel = 1; v = $urandom; last_rd = ~v;
    q.push_back(mk(0, 0, BASE, 1, 3'd2, v));
    q.push_back(mk(0, 0, BASE, 0, 3'd2, 32'h0));
    run_queue();
    checks++;
    if (last_rd !== v) begin
      failures++; $display("FAIL wait_read got=%h exp=%h", last_rd, v);
    end
  endtask

  task automatic test_errors(int s);
    sel = s; last_rd = 32'hFFFF_FFFF;
    q.push_back(mk(0, 0, BASE, 1, 3'd2, 32'hA5A55A5A));
    q.push_back(mk(0, 0, BASE + 32'h2, 1, 3'd2, $urandom));
    q.push_back(mk(0, 0, BASE, 0, 3'd2, 32'h0));
    q.push_back(mk(0, 0, BASE + 32'h1, 1, 3'd1, $urandom));
    q.push_back(mk(0, 0, BASE, 0, 3'd2, 32'h0));
    q.push_back(mk(0, 0, BASE, 1, 3'd3, $urandom));
    q.push_back(mk(0, 0, BASE, 0, 3'd2, 32'h0));
    q.push_back(mk(0, 0, BASE + 32'h400, 1, 3'd2, $urandom));
    q.push_back(mk(0, 0, BASE, 0, 3'd2, 32'h0));
    run_queue();
    checks++;
    if (last_rd !== 32'hA5A55A5A) begin
      failures++; $display("FAIL err_nowrite inst=%0d got=%h exp=a5a55a5a", s, last_rd);
    end
  endtask

  task automatic test_idle();
    sel = 0; last_rd = 32'hFFFF_FFFF;
    q.push_back(mk(0, 0, BASE + 32'h40, 1, 3'd2, 32'h0BADF00D));
    for (int i = 0; i < 12; i++) q.push_back(mk(1, 2'(i % 3), 32'h0, 0, 3'd0, 32'h0));
    q.push_back(mk(0, 0, BASE + 32'h40, 0, 3'd2, 32'h0));
    run_queue();
    checks++;
    if (last_rd !== 32'h0BADF00D) begin
      failures++; $display("FAIL idle_nowrite got=%h exp=0badf00d", last_rd);
    end
  endtask

  task automatic test_back_to_back(int s);
    logic [31:0] a;
    logic [2:0]  sz;
    sel = s;
    for (int w = 0; w < MEMB / 4; w++) q.push_back(mk(0, 0, BASE + 32'(w * 4), 1, 3'd2, $urandom));
    run_queue();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) q.push_back(mk(1, 2'($urandom_range(0, 2)), 32'h0, 0, 3'd0, 32'h0));
      else begin
        sz = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        a  = BASE + 32'($urandom_range(0, MEMB - 1));
        if ($urandom_range(0, 3) != 0 && sz < 3'd3) a = a & ~((32'd1 << sz) - 32'd1);
        if ($urandom_range(0, 15) == 0) a = BASE + 32'(MEMB) + 32'($urandom_range(0, 4095));
        q.push_back(mk(0, 0, a, 1'($urandom), sz, $urandom));
      end
    end
    run_queue();
  endtask

  task automatic test_reset_mid_write();
    sel = 2; last_rd = 32'hFFFF_FFFF;
    q.push_back(mk(0, 0, BASE + 32'h8, 1, 3'd2, 32'h0));
    run_queue();
    drive_addr(mk(0, 0, BASE + 32'h8, 1, 3'd2, 32'h0));
    hwdata = $urandom;
    @(posedge HCLK); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h1234_5678;
    checks++;
    if (o_rdy !== 1'b0) begin
      failures++; $display("FAIL rst_pre_wait got=%b exp=0", o_rdy);
    end
    @(posedge HCLK); #3;
    rst_n[2] = 1'b0;
    #1;
    checks++;
    if (o_rdy !== 1'b1 || o_resp !== 2'b00 || o_rdata !== 32'h0) begin
      failures++;
      $display("FAIL rst_async got=%b/%b/%h exp=1/00/0", o_rdy, o_resp, o_rdata);
    end
    @(posedge HCLK); @(posedge HCLK); #2;
    rst_n[2] = 1'b1;
    @(posedge HCLK); #1;
    q.push_back(mk(0, 0, BASE + 32'h8, 0, 3'd2, 32'h0));
    run_queue();
    checks++;
    if (last_rd !== 32'h0) begin
      failures++; $display("FAIL rst_no_commit got=%h exp=0", last_rd);
    end
  endtask

  initial begin
    test_reset();
    test_word_b2b();
    test_lanes();
    test_wait();
    test_errors(0);
    test_errors(1);
    test_idle();
    test_back_to_back(0);
    test_back_to_back(1);
    test_back_to_back(2);
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
